// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, oversample constants and vote helper for the UART receiver
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    localparam int OS_RATE = 16;
    localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);
    localparam logic [3:0] SAMPLE_A = 4'd7;
    localparam logic [3:0] SAMPLE_B = 4'd8;
    localparam logic [3:0] SAMPLE_C = 4'd9;
    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser with a configurable reset value
module uart_rx_sync #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: oversampled UART frame receiver with majority vote, parity/stop checks and valid/ready output
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
    rx_state_t state;
    logic rxs, samp_a, samp_b, vote, par_err;
    logic [3:0] os_cnt, bit_idx;
    logic [DATA_BITS-1:0] shreg;
    uart_rx_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rxs)
    );
    // third sample is taken live on the vote tick
    assign vote = majority(samp_a, samp_b, rxs);
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            os_cnt        <= '0;
            bit_idx       <= '0;
            samp_a        <= 1'b1;
            samp_b        <= 1'b1;
            shreg         <= '0;
            par_err       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (os_tick) begin
                if (state == IDLE) begin
                    if (!rxs) begin
                        state  <= START;
                        os_cnt <= '0;
                    end
                end else begin
                    os_cnt <= os_cnt + 4'd1;
                    if (os_cnt == SAMPLE_A) samp_a <= rxs;
                    if (os_cnt == SAMPLE_B) samp_b <= rxs;
                    case (state)
                        START: begin
                            if (os_cnt == SAMPLE_C && vote) begin
                                state  <= IDLE;
                                os_cnt <= '0;
                            end else if (os_cnt == OS_LAST) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end
                        end
                        DATA: begin
                            if (os_cnt == SAMPLE_C) shreg <= {vote, shreg[DATA_BITS-1:1]};
                            if (os_cnt == OS_LAST) begin
                                bit_idx <= bit_idx + 4'd1;
                                if (bit_idx == LAST_BIT) state <= (PARITY_EN != 0) ? PARITY : STOP;
                            end
                        end
                        PARITY: begin
                            if (os_cnt == SAMPLE_C) par_err <= (^shreg ^ vote) != 1'(PARITY_ODD);
                            if (os_cnt == OS_LAST) state <= STOP;
                        end
                        STOP: begin
                            if (os_cnt == SAMPLE_C) begin
                                state  <= IDLE;
                                os_cnt <= '0;
                                if (!rx_valid || rx_ready) begin
                                    rx_data       <= shreg;
                                    rx_frame_err  <= !vote;
                                    rx_parity_err <= (PARITY_EN != 0) && par_err;
                                    rx_valid      <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: randomized and directed checks of 8N1 and 8E1 receivers against a frame-level model
module tb_uart_rx_frame_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] tc = 2'd0;
    logic os_tick;
    logic rx_n = 1'b1, rx_p = 1'b1, rdy_n = 1'b1, rdy_p = 1'b1;
    logic [7:0] data_n, data_p;
    logic val_n, val_p, fe_n, fe_p, pe_n, pe_p, ovr_n, ovr_p, busy_n, busy_p;
    int checks = 0, errors = 0;
    int ovr_cnt = 0, val_cyc = 0, busy_cnt = 0;
    logic [9:0] q_n[$];
    logic [9:0] q_p[$];

    always #5 clk = ~clk;
    always @(posedge clk) tc <= tc + 2'd1;
    assign os_tick = tc == 2'd3;

    uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
        .clk(clk), .reset(reset), .os_tick(os_tick), .rx(rx_n),
        .rx_data(data_n), .rx_valid(val_n), .rx_ready(rdy_n),
        .rx_frame_err(fe_n), .rx_parity_err(pe_n), .overrun(ovr_n), .busy(busy_n)
    );
    uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .reset(reset), .os_tick(os_tick), .rx(rx_p),
        .rx_data(data_p), .rx_valid(val_p), .rx_ready(rdy_p),
        .rx_frame_err(fe_p), .rx_parity_err(pe_p), .overrun(ovr_p), .busy(busy_p)
    );

    always @(negedge clk) begin
        if (val_n && rdy_n) q_n.push_back({fe_n, pe_n, data_n});
        if (val_p && rdy_p) q_p.push_back({fe_p, pe_p, data_p});
        if (ovr_n) ovr_cnt <= ovr_cnt + 1;
        if (val_n) val_cyc <= val_cyc + 1;
        if (busy_n) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // frame-level model: word = data bits, stop bit 0 -> frame error, even parity mismatch -> parity error
    task automatic expect_word(input bit p, input logic [7:0] d, input bit pen, input bit pbit, input bit stop);
        logic [9:0] w;
        logic exp_pe;
        exp_pe = pen && ((^d ^ pbit) != 1'b0);
        check(p ? "qlen_p" : "qlen_n", p ? q_p.size() : q_n.size(), 1);
        w = '1;
        if (p && q_p.size() > 0) w = q_p.pop_front();
        if (!p && q_n.size() > 0) w = q_n.pop_front();
        check(p ? "data_p" : "data_n", w[7:0], d);
        check(p ? "frame_err_p" : "frame_err_n", w[9], !stop);
        check(p ? "parity_err_p" : "parity_err_n", w[8], exp_pe);
    endtask

    // each slot is 64 clk; the rx sample seen on os_cnt c lands 34+4*(c-7) clk into the slot
    task automatic send(input bit p, input logic [7:0] d, input bit pen, input bit pbit, input bit stop,
                        input int gs1, input int go1, input int gs2, input int go2, input int rst_slot);
        logic [10:0] bits;
        logic b;
        int ns;
        ns = pen ? 11 : 10;
        bits = pen ? {stop, pbit, d, 1'b0} : {1'b1, stop, d, 1'b0};
        do @(negedge clk); while (!os_tick);
        for (int s = 0; s < ns; s++) begin
            for (int k = 0; k < 64; k++) begin
                if (s == rst_slot && k == 16) begin
                    check("busy_before_reset", busy_n, 1);
                    reset = 1'b1;
                    @(negedge clk);
                    check("rst_mid_data", data_n, 0);
                    check("rst_mid_valid", val_n, 0);
                    check("rst_mid_flags", {fe_n, pe_n, ovr_n}, 0);
                    check("rst_mid_busy", busy_n, 0);
                    reset = 1'b0;
                    rx_n = 1'b1;
                    repeat (128) @(negedge clk);
                    return;
                end
                b = bits[s] ^ ((s == gs1 && k == go1) || (s == gs2 && k == go2));
                if (p) rx_p = b; else rx_n = b;
                @(negedge clk);
            end
        end
        rx_n = 1'b1;
        rx_p = 1'b1;
        repeat (128) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int o0, v0, b0;
        logic [7:0] d;
        bit st, pb;
        int gs;
        repeat (4) @(negedge clk);
        check("reset_data", data_n, 0);
        check("reset_valid", val_n, 0);
        check("reset_flags", {fe_n, pe_n, ovr_n}, 0);
        check("reset_busy", busy_n, 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("idle_busy", busy_n, 0);

        o0 = ovr_cnt; v0 = val_cyc;
        send(0, 8'hA5, 0, 0, 1, -1, 0, -1, 0, -1);
        expect_word(0, 8'hA5, 0, 0, 1);
        check("a5_valid_cycles", val_cyc - v0, 1);
        check("a5_no_overrun", ovr_cnt - o0, 0);

        send(1, 8'h03, 1, 1, 1, -1, 0, -1, 0, -1);
        expect_word(1, 8'h03, 1, 1, 1);
        send(1, 8'h03, 1, 0, 1, -1, 0, -1, 0, -1);
        expect_word(1, 8'h03, 1, 0, 1);

        b0 = busy_cnt; v0 = val_cyc;
        rx_n = 1'b0;
        repeat (20) @(negedge clk);
        rx_n = 1'b1;
        repeat (100) @(negedge clk);
        check("fs_busy_seen", busy_cnt > b0, 1);
        check("fs_busy_low", busy_n, 0);
        check("fs_no_valid", val_cyc - v0, 0);
        check("fs_no_word", q_n.size(), 0);

        send(0, 8'h55, 0, 0, 0, -1, 0, -1, 0, -1);
        expect_word(0, 8'h55, 0, 0, 0);
        send(0, 8'h12, 0, 0, 1, -1, 0, -1, 0, -1);
        expect_word(0, 8'h12, 0, 0, 1);

        @(posedge clk); #1 rdy_n = 1'b0;
        o0 = ovr_cnt;
        send(0, 8'h11, 0, 0, 1, -1, 0, -1, 0, -1);
        send(0, 8'h22, 0, 0, 1, -1, 0, -1, 0, -1);
        check("ovr_held_data", data_n, 8'h11);
        check("ovr_held_valid", val_n, 1);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_no_transfer", q_n.size(), 0);
        @(posedge clk); #1 rdy_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        expect_word(0, 8'h11, 0, 0, 1);
        check("ovr_valid_drop", val_n, 0);

        o0 = ovr_cnt; v0 = val_cyc;
        send(0, 8'h3C, 0, 0, 1, -1, 0, -1, 0, 4);
        check("rst_no_valid", val_cyc - v0, 0);
        check("rst_no_overrun", ovr_cnt - o0, 0);
        send(0, 8'h7E, 0, 0, 1, -1, 0, -1, 0, -1);
        expect_word(0, 8'h7E, 0, 0, 1);

        send(0, 8'hC3, 0, 0, 1, 2, 34, 7, 42, -1);
        expect_word(0, 8'hC3, 0, 0, 1);

        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            st = $urandom_range(0, 7) != 0;
            gs = $urandom_range(0, 9);
            send(0, d, 0, 0, st, gs, 34 + 4 * $urandom_range(0, 2), -1, 0, -1);
            expect_word(0, d, 0, 0, st);
        end
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            pb = 1'($urandom);
            st = $urandom_range(0, 5) != 0;
            send(1, d, 1, pb, st, -1, 0, -1, 0, -1);
            expect_word(1, d, 1, pb, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
